// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the MIPS ID stage: ALU op/class codes,
// primary opcodes and SPECIAL funct values.
package id_stage_pipe_pkg;

  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  // ALU operation codes carried to EX
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_LUI_OP  = 8'b0101_1100;

  // Result class selecting which EX unit produces the write-back value
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;

  // Primary opcodes inst[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct codes inst[5:0]
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// Single read-port operand resolver: picks immediate, $0, EX/MEM bypass or
// regfile data, and flags a hazard the stage must stall for.
module id_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              re,
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data,
  output logic              hazard
);

  logic addr_nz;
  logic ex_hit;
  logic mem_hit;

  assign addr_nz = (addr != '0);
  assign ex_hit  = re & addr_nz & ex_we  & (ex_waddr  == addr);
  assign mem_hit = re & addr_nz & mem_we & (mem_waddr == addr);

  // Operand select; EX is younger than MEM so it takes priority
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    data   = rdata;
    hazard = 1'b0;
    if (!re) begin
      data = imm;
    end else if (!addr_nz) begin
      data = '0;
    end else if (FWD_EN) begin
      // A load's data is not ready in EX: stall rather than forward it
      hazard = ex_hit & ex_is_load;
      if (ex_hit && !ex_is_load) data = ex_wdata;
      else if (mem_hit)          data = mem_wdata;
    end else begin
      // No bypass network: any pending write to a source must retire first
      hazard = ex_hit | mem_hit;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: decodes the immediate logic/arith subset and SPECIAL
// R-type, resolves operands through EX/MEM forwarding, stalls on load-use,
// and holds the result in a valid/ready ID/EX register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     pc_i,
  input  logic [31:0]         inst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic                re1_o,
  output logic                re2_o,
  output logic [REG_AW-1:0]   raddr1_o,
  output logic [REG_AW-1:0]   raddr2_o,
  input  logic [DATA_W-1:0]   rdata1_i,
  input  logic [DATA_W-1:0]   rdata2_i,
  input  logic                ex_we_i,
  input  logic                ex_is_load_i,
  input  logic [REG_AW-1:0]   ex_waddr_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                mem_we_i,
  input  logic [REG_AW-1:0]   mem_waddr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   data1_o,
  output logic [DATA_W-1:0]   data2_o,
  output logic                we_o,
  output logic [REG_AW-1:0]   waddr_o,
  output logic [PC_W-1:0]     pc_o,
  output logic                inst_err_o
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [4:0]  sa;
  logic [4:0]  rd;
  logic [4:0]  rt;

  assign op    = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign imm16 = inst_i[15:0];
  assign sa    = inst_i[10:6];
  assign rd    = inst_i[15:11];
  assign rt    = inst_i[20:16];

  assign raddr1_o = REG_AW'(inst_i[25:21]);
  assign raddr2_o = REG_AW'(rt);

  logic [ALUOP_W-1:0]  dec_aluop;
  logic [ALUSEL_W-1:0] dec_alusel;
  logic                dec_we;
  logic [REG_AW-1:0]   dec_waddr;
  logic                dec_err;
  logic [DATA_W-1:0]   dec_imm1;
  logic [DATA_W-1:0]   dec_imm2;
  logic                r_type;
  logic                s_type;
  logic                i_type;
  logic                i_uses_rs;

  // Instruction decode: op/class, read enables, write target and immediates
  always_comb begin
    dec_aluop  = EXE_NOP_OP;
    dec_alusel = EXE_RES_NOP;
    dec_err    = 1'b0;
    r_type     = 1'b0;
    s_type     = 1'b0;
    i_type     = 1'b0;
    i_uses_rs  = 1'b1;
    dec_imm2   = '0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_AND:  begin dec_aluop = EXE_AND_OP;  dec_alusel = EXE_RES_LOGIC; r_type = 1'b1; end
          FN_OR:   begin dec_aluop = EXE_OR_OP;   dec_alusel = EXE_RES_LOGIC; r_type = 1'b1; end
          FN_XOR:  begin dec_aluop = EXE_XOR_OP;  dec_alusel = EXE_RES_LOGIC; r_type = 1'b1; end
          FN_NOR:  begin dec_aluop = EXE_NOR_OP;  dec_alusel = EXE_RES_LOGIC; r_type = 1'b1; end
          FN_ADDU: begin dec_aluop = EXE_ADDU_OP; dec_alusel = EXE_RES_ARITH; r_type = 1'b1; end
          FN_SUBU: begin dec_aluop = EXE_SUBU_OP; dec_alusel = EXE_RES_ARITH; r_type = 1'b1; end
          FN_SLT:  begin dec_aluop = EXE_SLT_OP;  dec_alusel = EXE_RES_ARITH; r_type = 1'b1; end
          FN_SLL:  begin dec_aluop = EXE_SLL_OP;  dec_alusel = EXE_RES_SHIFT; s_type = 1'b1; end
          FN_SRL:  begin dec_aluop = EXE_SRL_OP;  dec_alusel = EXE_RES_SHIFT; s_type = 1'b1; end
          FN_SRA:  begin dec_aluop = EXE_SRA_OP;  dec_alusel = EXE_RES_SHIFT; s_type = 1'b1; end
          default: dec_err = 1'b1;
        endcase
      end
      OP_ORI: begin
        dec_aluop = EXE_OR_OP;  dec_alusel = EXE_RES_LOGIC; i_type = 1'b1;
        dec_imm2  = DATA_W'(imm16);
      end
      OP_ANDI: begin
        dec_aluop = EXE_AND_OP; dec_alusel = EXE_RES_LOGIC; i_type = 1'b1;
        dec_imm2  = DATA_W'(imm16);
      end
      OP_XORI: begin
        dec_aluop = EXE_XOR_OP; dec_alusel = EXE_RES_LOGIC; i_type = 1'b1;
        dec_imm2  = DATA_W'(imm16);
      end
      OP_LUI: begin
        dec_aluop = EXE_LUI_OP; dec_alusel = EXE_RES_LOGIC; i_type = 1'b1;
        i_uses_rs = 1'b0;
        // Narrow datapaths keep only the low DATA_W bits of the shifted value
        dec_imm2  = DATA_W'({imm16, 16'h0000});
      end
      OP_ADDIU: begin
        dec_aluop = EXE_ADDU_OP; dec_alusel = EXE_RES_ARITH; i_type = 1'b1;
        dec_imm2  = DATA_W'($signed(imm16));
      end
      OP_SLTI: begin
        dec_aluop = EXE_SLT_OP;  dec_alusel = EXE_RES_ARITH; i_type = 1'b1;
        dec_imm2  = DATA_W'($signed(imm16));
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Port usage and write target derived from the instruction class
  always_comb begin
    re1_o     = 1'b0;
    re2_o     = 1'b0;
    dec_we    = 1'b0;
    dec_waddr = '0;
    dec_imm1  = '0;
    if (r_type) begin
      re1_o     = 1'b1;
      re2_o     = 1'b1;
      dec_we    = 1'b1;
      dec_waddr = REG_AW'(rd);
    end else if (s_type) begin
      re2_o     = 1'b1;
      dec_we    = 1'b1;
      dec_waddr = REG_AW'(rd);
      dec_imm1  = DATA_W'(sa);
    end else if (i_type) begin
      re1_o     = i_uses_rs;
      dec_we    = 1'b1;
      dec_waddr = REG_AW'(rt);
    end
  end

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              haz1;
  logic              haz2;

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd1 (
    .re         (re1_o),
    .addr       (raddr1_o),
    .imm        (dec_imm1),
    .rdata      (rdata1_i),
    .ex_we      (ex_we_i),
    .ex_is_load (ex_is_load_i),
    .ex_waddr   (ex_waddr_i),
    .ex_wdata   (ex_wdata_i),
    .mem_we     (mem_we_i),
    .mem_waddr  (mem_waddr_i),
    .mem_wdata  (mem_wdata_i),
    .data       (op1),
    .hazard     (haz1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd2 (
    .re         (re2_o),
    .addr       (raddr2_o),
    .imm        (dec_imm2),
    .rdata      (rdata2_i),
    .ex_we      (ex_we_i),
    .ex_is_load (ex_is_load_i),
    .ex_waddr   (ex_waddr_i),
    .ex_wdata   (ex_wdata_i),
    .mem_we     (mem_we_i),
    .mem_waddr  (mem_waddr_i),
    .mem_wdata  (mem_wdata_i),
    .data       (op2),
    .hazard     (haz2)
  );

  logic stall;
  logic accept;

  assign stall      = in_valid_i & (haz1 | haz2);
  assign in_ready_o = (!out_valid_o | out_ready_i) & !stall & !flush_i;
  assign accept     = in_valid_i & in_ready_o;

  // ID/EX register: flush kills, accept loads, drain without accept bubbles
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the whole ID/EX register is reset asynchronously so EX never sees stale payload.
    if (!rst) begin
      out_valid_o <= 1'b0;
      we_o        <= 1'b0;
      inst_err_o  <= 1'b0;
      aluop_o     <= EXE_NOP_OP;
      alusel_o    <= EXE_RES_NOP;
      data1_o     <= '0;
      data2_o     <= '0;
      waddr_o     <= '0;
      pc_o        <= '0;
    end else if (flush_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      out_valid_o <= 1'b0;
      we_o        <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      we_o        <= dec_we;
      inst_err_o  <= dec_err;
      aluop_o     <= dec_aluop;
      alusel_o    <= dec_alusel;
      data1_o     <= op1;
      data2_o     <= op2;
      waddr_o     <= dec_waddr;
      pc_o        <= pc_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
      we_o        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: expected results are queued when an
// instruction is accepted and compared when EX takes it from the stage.
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 32;

  logic                clk;
  logic                rst;
  logic [PW-1:0]       pc_i;
  logic [31:0]         inst_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic                re1_o, re2_o;
  logic [AW-1:0]       raddr1_o, raddr2_o;
  logic [DW-1:0]       rdata1_i, rdata2_i;
  logic                ex_we_i, ex_is_load_i;
  logic [AW-1:0]       ex_waddr_i;
  logic [DW-1:0]       ex_wdata_i;
  logic                mem_we_i;
  logic [AW-1:0]       mem_waddr_i;
  logic [DW-1:0]       mem_wdata_i;
  logic                flush_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [ALUOP_W-1:0]  aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic [DW-1:0]       data1_o, data2_o;
  logic                we_o;
  logic [AW-1:0]       waddr_o;
  logic [PW-1:0]       pc_o;
  logic                inst_err_o;

  id_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .PC_W(PW), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .re1_o(re1_o), .re2_o(re2_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
    .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i),
    .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .data1_o(data1_o), .data2_o(data2_o),
    .we_o(we_o), .waddr_o(waddr_o), .pc_o(pc_o), .inst_err_o(inst_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DW-1:0]       d1;
    logic [DW-1:0]       d2;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [PW-1:0]       pc;
    logic                err;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic [ALUOP_W-1:0] aluop, input logic [ALUSEL_W-1:0] alusel,
                              input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic we,
                              input logic [AW-1:0] waddr, input logic [PW-1:0] pc, input logic err);
    exp_t e;
    e.aluop = aluop; e.alusel = alusel; e.d1 = d1; e.d2 = d2;
    e.we = we; e.waddr = waddr; e.pc = pc; e.err = err;
    return e;
  endfunction

  // Scoreboard: compare every instruction EX takes against the queued expectation
  always @(negedge clk) begin
    if (rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_aluop",  aluop_o,    e.aluop);
        check("out_alusel", alusel_o,   e.alusel);
        check("out_data1",  data1_o,    e.d1);
        check("out_data2",  data2_o,    e.d2);
        check("out_we",     we_o,       e.we);
        check("out_waddr",  waddr_o,    e.waddr);
        check("out_pc",     pc_o,       e.pc);
        check("out_err",    inst_err_o, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and wait (bounded) until the stage accepts it
  task automatic issue(input logic [PW-1:0] pc, input logic [31:0] inst,
                       input logic [DW-1:0] r1, input logic [DW-1:0] r2, input exp_t e);
    bit done;
    done = 1'b0;
    pc_i = pc; inst_i = inst; rdata1_i = r1; rdata2_i = r2; in_valid_i = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (in_ready_o) begin
        sb.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    if (!done) check("issue_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int c0;

  initial begin
    rst = 1'b0; pc_i = '0; inst_i = '0; in_valid_i = 1'b0;
    rdata1_i = '0; rdata2_i = '0;
    ex_we_i = 1'b0; ex_is_load_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
    mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
    flush_i = 1'b0; out_ready_i = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_valid",  out_valid_o, 0);
    check("rst_we",     we_o,        0);
    check("rst_err",    inst_err_o,  0);
    check("rst_aluop",  aluop_o,     EXE_NOP_OP);
    check("rst_alusel", alusel_o,    EXE_RES_NOP);
    check("rst_data1",  data1_o,     0);
    check("rst_data2",  data2_o,     0);
    check("rst_waddr",  waddr_o,     0);
    check("rst_pc",     pc_o,        0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ori $2,$1,0xFF00 from regfile, 1-cycle latency, then bubble
    issue(32'h100, 32'h3422FF00, 32'h12340011, 32'h0,
          mk(EXE_OR_OP, EXE_RES_LOGIC, 32'h12340011, 32'h0000FF00, 1'b1, 5'd2, 32'h100, 1'b0));
    check("ori_valid", out_valid_o, 1);
    in_valid_i = 1'b0;
    #1;
    check("ori_re1",    re1_o,    1);
    check("ori_re2",    re2_o,    0);
    check("ori_raddr1", raddr1_o, 1);
    check("ori_raddr2", raddr2_o, 2);
    tick();
    check("bubble_valid", out_valid_o, 0);
    check("bubble_we",    we_o,        0);
    check("bubble_waddr", waddr_o,     2);
    check("bubble_data1", data1_o,     32'h12340011);

    // addiu $3,$3,-4: EX beats MEM on the same address
    ex_we_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'd10;
    mem_we_i = 1'b1; mem_waddr_i = 5'd3; mem_wdata_i = 32'd7;
    issue(32'h104, 32'h2463FFFC, 32'h0000DEAD, 32'h0,
          mk(EXE_ADDU_OP, EXE_RES_ARITH, 32'd10, 32'hFFFFFFFC, 1'b1, 5'd3, 32'h104, 1'b0));

    // xori $5,$4,0x8001: MEM-only forward, zero-extended immediate
    ex_waddr_i = 5'd7; mem_waddr_i = 5'd4; mem_wdata_i = 32'h55;
    issue(32'h108, 32'h38858001, 32'h0000BEEF, 32'h0,
          mk(EXE_XOR_OP, EXE_RES_LOGIC, 32'h55, 32'h00008001, 1'b1, 5'd5, 32'h108, 1'b0));

    // lui $7,0xABCD: rs not read even though EX writes $7
    issue(32'h10C, 32'h3C07ABCD, 32'h00001111, 32'h0,
          mk(EXE_LUI_OP, EXE_RES_LOGIC, 32'h0, 32'hABCD0000, 1'b1, 5'd7, 32'h10C, 1'b0));

    // slti $8,$0,-1: $0 reads zero even with a pending EX write to $0
    ex_waddr_i = 5'd0; ex_wdata_i = 32'd5; mem_we_i = 1'b0;
    issue(32'h110, 32'h2808FFFF, 32'h00000999, 32'h0,
          mk(EXE_SLT_OP, EXE_RES_ARITH, 32'h0, 32'hFFFFFFFF, 1'b1, 5'd8, 32'h110, 1'b0));

    // Load-use on rt of addu $4,$5,$6
    ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd6;
    pc_i = 32'h114; inst_i = 32'h00A62021; rdata1_i = 32'h11; rdata2_i = 32'h22; in_valid_i = 1'b1;
    #1;
    check("lu_ready", in_ready_o, 0);
    tick();
    check("lu_bubble_valid", out_valid_o, 0);
    check("lu_bubble_we",    we_o,        0);
    #1;
    check("lu_ready_again", in_ready_o, 0);
    ex_we_i = 1'b0; ex_is_load_i = 1'b0;
    issue(32'h114, 32'h00A62021, 32'h11, 32'h22,
          mk(EXE_ADDU_OP, EXE_RES_ARITH, 32'h11, 32'h22, 1'b1, 5'd4, 32'h114, 1'b0));

    // Load targeting $0 never stalls: or $9,$0,$2
    ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd0;
    issue(32'h118, 32'h00024825, 32'h77, 32'h33,
          mk(EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h33, 1'b1, 5'd9, 32'h118, 1'b0));
    ex_we_i = 1'b0; ex_is_load_i = 1'b0;

    // Backpressure: hold or $9 for 3 cycles with sra waiting upstream
    out_ready_i = 1'b0;
    pc_i = 32'h11C; inst_i = 32'h000B5103; rdata1_i = 32'h0; rdata2_i = 32'h80000000; in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", in_ready_o, 0);
      tick();
      check("bp_valid", out_valid_o, 1);
      check("bp_pc",    pc_o,        32'h118);
      check("bp_data2", data2_o,     32'h33);
      check("bp_waddr", waddr_o,     9);
    end
    out_ready_i = 1'b1;
    c0 = cyc;
    issue(32'h11C, 32'h000B5103, 32'h0, 32'h80000000,
          mk(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000, 1'b1, 5'd10, 32'h11C, 1'b0));
    check("stream_valid0", out_valid_o, 1);
    issue(32'h120, 32'h01AE6027, 32'h0F0F, 32'hF0F0,
          mk(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0F0F, 32'hF0F0, 1'b1, 5'd12, 32'h120, 1'b0));
    check("stream_valid1", out_valid_o, 1);
    // All-zero word is sll $0,$0,0: legal, writes $0
    issue(32'h124, 32'h00000000, 32'h5, 32'h6,
          mk(EXE_SLL_OP, EXE_RES_SHIFT, 32'h0, 32'h0, 1'b1, 5'd0, 32'h124, 1'b0));
    check("stream_valid2", out_valid_o, 1);
    check("stream_cycles", cyc - c0, 3);

    // Undecodable encodings
    issue(32'h128, 32'hFC000000, 32'h1, 32'h2,
          mk(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h128, 1'b1));
    check("ill_err", inst_err_o, 1);
    check("ill_we",  we_o,       0);
    issue(32'h12C, 32'h0000003F, 32'h1, 32'h2,
          mk(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h12C, 1'b1));
    in_valid_i = 1'b0;
    tick();

    // Flush blocks an incoming instruction
    flush_i = 1'b1; pc_i = 32'h200; inst_i = 32'h3422FF00; in_valid_i = 1'b1;
    #1;
    check("fl_ready", in_ready_o, 0);
    tick();
    check("fl_valid", out_valid_o, 0);
    flush_i = 1'b0;

    // Flush kills a held instruction even under backpressure
    out_ready_i = 1'b0;
    #1;
    check("fl2_ready", in_ready_o, 1);
    tick();
    check("fl2_held_valid", out_valid_o, 1);
    check("fl2_held_pc",    pc_o,        32'h200);
    in_valid_i = 1'b0; flush_i = 1'b1;
    tick();
    check("fl2_valid", out_valid_o, 0);
    check("fl2_we",    we_o,        0);
    flush_i = 1'b0;

    // Asynchronous reset while an instruction is held
    pc_i = 32'h300; in_valid_i = 1'b1;
    #1;
    tick();
    in_valid_i = 1'b0;
    check("ar_held_valid", out_valid_o, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", out_valid_o, 0);
    check("ar_we",    we_o,        0);
    check("ar_pc",    pc_o,        0);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised decode stage for the MIPS core, sitting between IF/ID and EX.
- Decodes the immediate-logic/arithmetic subset plus SPECIAL R-type, and drives register-file read ports.
- Resolves operands with EX/MEM forwarding, detects load-use hazards and stalls for them.
- Holds an ID/EX output register with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, operand/data width.
- REG_AW, 5, register address width.
- PC_W, 32, instruction address width.
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = regfile data only, and any RAW on a pending EX/MEM write stalls.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- pc_i  in  PC_W  instruction address.
- inst_i  in  32  instruction word.
- in_valid_i  in  1  upstream instruction valid.
- in_ready_o  out  1  stage accepts inst_i this cycle.
- re1_o, re2_o  out  1 each  regfile read enables.
- raddr1_o, raddr2_o  out  REG_AW each  regfile read addresses: inst[25:21], inst[20:16].
- rdata1_i, rdata2_i  in  DATA_W each  regfile read data, combinational.
- ex_we_i, ex_is_load_i  in  1 each  EX-stage write pending / EX op is a load.
- ex_waddr_i  in  REG_AW  EX write address.
- ex_wdata_i  in  DATA_W  EX write data.
- mem_we_i  in  1  MEM-stage write pending.
- mem_waddr_i  in  REG_AW  MEM write address.
- mem_wdata_i  in  DATA_W  MEM write data.
- flush_i  in  1  kill held and incoming instruction.
- out_valid_o  out  1  ID/EX register holds an instruction.
- out_ready_i  in  1  EX accepts.
- aluop_o  out  ALUOP_W  ALU operation.
- alusel_o  out  ALUSEL_W  result class.
- data1_o, data2_o  out  DATA_W each  resolved operands.
- we_o  out  1  write-back enable.
- waddr_o  out  REG_AW  write-back address.
- pc_o  out  PC_W  pc of held instruction.
- inst_err_o  out  1  held instruction was undecodable.

Behaviour:
- Reset (rst=0, async): out_valid_o=0, we_o=0, inst_err_o=0, aluop_o=NOP, alusel_o=NOP, data1_o=data2_o=0, waddr_o=0, pc_o=0.
- Decode (combinational from inst_i):
  - ORI/ANDI/XORI: zero-extend imm16.
  - LUI: operand = {imm16, 16'h0}; re1=0.
  - ADDIU/SLTI: sign-extend imm16.
  - All I-type: re1=1, re2=0, waddr=inst[20:16], data2 = extended immediate.
  - SPECIAL funct AND/OR/XOR/NOR/ADDU/SUBU/SLT: re1=re2=1, waddr=inst[15:11].
  - SLL/SRL/SRA: re1=0, re2=1, data1 = zero-extended sa (inst[10:6]), data2 = rt.
  - Any other encoding: NOP, we=0, inst_err=1. All-zero word is SLL $0 (legal, we=1, waddr=0).
- Operand resolve, per read port when re=1:
  - Address 0 → 0.
  - else EX match (ex_we_i, addr equal, !ex_is_load_i) → ex_wdata_i.
  - else MEM match → mem_wdata_i.
  - else rdata.
  - EX has priority over MEM.
  - re=0 → immediate/sa as above.
- Load-use stall: in_valid_i & ex_we_i & ex_is_load_i & ex_waddr_i≠0 & match on an enabled port. With FWD_EN=0, any EX/MEM match on an enabled port also stalls.
- Handshakes:
  - in_ready_o = (!out_valid_o | out_ready_i) & !stall & !flush_i.
  - Accept = in_valid_i & in_ready_o. Output register loads on accept, 1-cycle latency.
  - If out_ready_i & !accept: out_valid_o←0 (bubble). Payload fields hold; we_o forced 0.
  - If !out_ready_i: all outputs hold stable, including during a stall.
- flush_i=1: next edge out_valid_o←0, we_o←0; inst_i not accepted. Flush wins over accept and stall.
- Arithmetic: the stage does no ALU math. Immediates extend to DATA_W; DATA_W<32 truncates LUI result to the low DATA_W bits.

Decomposition:
- Shared package/defines (extend the existing define header):
  - ALUOP_W=8, ALUSEL_W=3.
  - EXE_*_OP codes (AND, OR, XOR, NOR, ADDU, SUBU, SLT, SLL, SRL, SRA, LUI, NOP).
  - EXE_RES_* classes (NOP, LOGIC, SHIFT, ARITH).
  - Opcode/funct constants.
- One sub-module, id_fwd_mux: single-port operand resolver (address, re, imm, rdata, EX/MEM taps → data, hazard flag), instantiated twice.

Test Plan:
- Reset mid-transfer: ORI held with out_valid_o=1, drive rst=0 → out_valid_o=0, we_o=0 immediately, without waiting for a clock edge.
- ori $2,$1,0xFF00 (0x3422FF00), rdata1=0x12340011, no forwarding → one cycle later:
  - aluop=OR, data1=0x12340011, data2=0x0000FF00, waddr=2, we=1.
- addiu $3,$3,-4 (0x2463FFFC), ex_we=1, ex_waddr=3, ex_wdata=10, mem_waddr=3, mem_wdata=7 → data1=10 (EX priority), data2=0xFFFFFFFC.
- Load-use: addu $4,$5,$6 (0x00A62021) with ex_is_load=1, ex_waddr=6:
  - in_ready_o=0, bubble emitted.
  - Next cycle ex_is_load=0 → accepted, data2=rdata2.
- Backpressure: out_ready_i=0 for 3 cycles with in_valid_i=1 → in_ready_o=0, outputs stable. Release → exactly one new instruction per cycle.
- Flush and error:
  - flush_i with in_valid_i=1 → out_valid_o=0 next cycle, no accept.
  - Illegal word 0xFC000000 → inst_err_o=1, we_o=0, aluop=NOP.
